mdu: RTL and testbench

Multi-cycle multiply/divide unit for the datapath, placed beside the register file in the execute stage. It takes the two register-file read results as operands and holds the products and quotients in private HI/LO registers. Software reads HI/LO back into the register file through the normal write-back path. The unit models multiply and divide latency with a `busy` flag; the hazard logic stalls on that flag.

---
 rtl/mdu.sv | 141 ++++++++++++++
 tb/tb_mdu.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with private HI/LO registers.
// The result is computed at the start edge and committed after a programmable busy delay.
module mdu #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  op,
   input  logic        start,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_e;

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6,
      OP_RSVD  = 3'd7
   } op_e;

   state_e      state, state_nxt;
   op_e         op_c;
   logic [7:0]  cnt;
   logic [63:0] pending;
   logic        pend_wr;

   logic        launch, done, is_div;
   logic [63:0] result;
   logic        result_wr;

   logic [63:0] prod_s, prod_u;
   logic        div_signed;
   logic [31:0] num, den, den_safe, q_u, r_u, quo, rem;

   assign op_c = op_e'(op);
   assign busy = (state == S_RUN);

   // Sign-extended/zero-extended 64-bit products; low 64 bits are exact for both forms
   assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
   assign prod_u = {32'd0, a} * {32'd0, b};

   // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000
   assign div_signed = (op_c == OP_DIV);
   assign num        = (div_signed && a[31]) ? (~a + 32'd1) : a;
   assign den        = (div_signed && b[31]) ? (~b + 32'd1) : b;
   assign den_safe   = (den == '0) ? 32'd1 : den;
   assign q_u        = num / den_safe;
   assign r_u        = num % den_safe;
   assign quo        = (div_signed && (a[31] ^ b[31])) ? (~q_u + 32'd1) : q_u;
   assign rem        = (div_signed && a[31]) ? (~r_u + 32'd1) : r_u;

   always_comb begin
      result    = '0;
      result_wr = 1'b0;
      is_div    = 1'b0;
      unique case (op_c)
         OP_MULT: begin
            result    = prod_s;
            result_wr = 1'b1;
         end
         OP_MULTU: begin
            result    = prod_u;
            result_wr = 1'b1;
         end
         OP_DIV, OP_DIVU: begin
            result    = {rem, quo};
            result_wr = (b != '0);
            is_div    = 1'b1;
         end
         default: begin
            result    = '0;
            result_wr = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      launch    = 1'b0;
      done      = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start && (op_c == OP_MULT || op_c == OP_MULTU ||
                          op_c == OP_DIV  || op_c == OP_DIVU)) begin
               launch    = 1'b1;
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (cnt == 8'd1) begin
               done      = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         pending <= '0;
         pend_wr <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         if (launch) begin
            pending <= result;
            pend_wr <= result_wr;
            cnt     <= is_div ? 8'(DIV_CYCLES) : 8'(MULT_CYCLES);
         end else if (state == S_RUN) begin
            cnt <= cnt - 8'd1;
            if (done && pend_wr) begin
               hi <= pending[63:32];
               lo <= pending[31:0];
            end
         end
         if (state == S_IDLE && start && op_c == OP_MTHI) hi <= a;
         if (state == S_IDLE && start && op_c == OP_MTLO) lo <= a;
      end
   end

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu: table of arithmetic vectors plus
// hand-written sequences for divide-by-zero, start-while-busy and async reset.
module tb_mdu;

   logic        clk;
   logic        reset;
   logic [31:0] a, b;
   logic [2:0]  op;
   logic        start;
   logic        busy;
   logic [31:0] hi, lo;

   int total;
   int bad;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          cycles;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t tbl[10];

   mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .a     (a),
      .b     (b),
      .op    (op),
      .start (start),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Drive one start pulse; returns at the falling edge just after the start edge.
   task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
      @(negedge clk);
      op    = o;
      a     = va;
      b     = vb;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      op    = 3'd0;
   endtask

   // Counts falling edges with busy high, toggling operands meanwhile.
   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 300) begin
         n++;
         a = $urandom;
         b = $urandom;
         @(negedge clk);
      end
   endtask

   initial begin
      int n;
      logic [31:0] prev_hi, prev_lo;

      total = 0;
      bad   = 0;
      a     = '0;
      b     = '0;
      op    = '0;
      start = 1'b0;
      reset = 1'b1;

      tbl[0] = '{3'd1, 32'hFFFFFFFD, 32'h00000005, 5,  32'hFFFFFFFF, 32'hFFFFFFF1};
      tbl[1] = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 5,  32'h00000001, 32'hFFFFFFFE};
      tbl[2] = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
      tbl[3] = '{3'd4, 32'h00000007, 32'h00000002, 10, 32'h00000001, 32'h00000003};
      tbl[4] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
      tbl[5] = '{3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 5,  32'h3FFFFFFF, 32'h00000001};
      tbl[6] = '{3'd1, 32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000};
      tbl[7] = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
      tbl[8] = '{3'd4, 32'hFFFFFFFF, 32'h00000010, 10, 32'h0000000F, 32'h0FFFFFFF};
      tbl[9] = '{3'd2, 32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000};

      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);

      prev_hi = '0;
      prev_lo = '0;
      for (int i = 0; i < 10; i++) begin
         issue(tbl[i].op, tbl[i].a, tbl[i].b);
         chk($sformatf("v%0d_hi_in_run", i), hi, prev_hi);
         chk($sformatf("v%0d_lo_in_run", i), lo, prev_lo);
         wait_idle(n);
         chk($sformatf("v%0d_busy_cycles", i), n, tbl[i].cycles);
         chk($sformatf("v%0d_hi", i), hi, tbl[i].exp_hi);
         chk($sformatf("v%0d_lo", i), lo, tbl[i].exp_lo);
         prev_hi = tbl[i].exp_hi;
         prev_lo = tbl[i].exp_lo;
      end

      // Divide by zero leaves HI/LO untouched but still takes the full latency
      issue(3'd5, 32'h12345678, 32'd0);
      chk("mthi_hi", hi, 32'h12345678);
      chk("mthi_busy", {31'd0, busy}, 32'd0);
      issue(3'd6, 32'h9ABCDEF0, 32'd0);
      chk("mtlo_lo", lo, 32'h9ABCDEF0);
      issue(3'd4, 32'h00000064, 32'd0);
      wait_idle(n);
      chk("div0_busy_cycles", n, 10);
      chk("div0_hi", hi, 32'h12345678);
      chk("div0_lo", lo, 32'h9ABCDEF0);

      // Starts during RUN, including the one sampled on the completing edge, are ignored
      issue(3'd2, 32'd3, 32'd4);
      n = 0;
      while (busy && n < 300) begin
         n++;
         if (n == 1) begin
            start = 1'b1; op = 3'd6; a = 32'hDEADBEEF; b = 32'd0;
         end else if (n == 2) begin
            op = 3'd3; a = 32'd100; b = 32'd7;
         end else if (n == 5) begin
            start = 1'b1; op = 3'd2; a = 32'd5; b = 32'd6;
         end else begin
            start = 1'b0; op = 3'd0;
         end
         @(negedge clk);
      end
      chk("sb_busy_cycles", n, 5);
      chk("sb_busy_low", {31'd0, busy}, 32'd0);
      chk("sb_hi", hi, 32'd0);
      chk("sb_lo", lo, 32'd12);
      @(negedge clk);
      start = 1'b0;
      op    = 3'd0;
      chk("b2b_accepted", {31'd0, busy}, 32'd1);
      wait_idle(n);
      chk("b2b_busy_cycles", n, 5);
      chk("b2b_hi", hi, 32'd0);
      chk("b2b_lo", lo, 32'd30);

      // Asynchronous reset in the middle of a divide
      issue(3'd5, 32'hAAAA0000, 32'd0);
      chk("rst_mthi", hi, 32'hAAAA0000);
      issue(3'd3, 32'd100, 32'd7);
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("rst_async_busy", {31'd0, busy}, 32'd0);
      chk("rst_async_hi", hi, 32'd0);
      chk("rst_async_lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      chk("rst_abort_busy", {31'd0, busy}, 32'd0);
      chk("rst_abort_hi", hi, 32'd0);
      chk("rst_abort_lo", lo, 32'd0);
      issue(3'd6, 32'h00000055, 32'd0);
      chk("rst_mtlo_lo", lo, 32'h00000055);
      chk("rst_mtlo_hi", hi, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
